// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package mips_fetch_pkg;

    typedef enum logic [2:0] {
        StRst,
        StReq,
        StWait,
        StExec,
        StNext,
        StErr
    } fetch_state_e;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Branch immediates are word offsets; scale to bytes and sign-extend.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: request/address out, ack/data back.
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection from execute feedback; jump beats branch.
module next_pc_calc
    import mips_fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        branch_i,
    input  logic        jump_i,
    input  logic        zero_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] index_i,
    output logic [31:0] next_pc_o
);

    logic [31:0] p4;

    assign p4 = pc_i + 32'd4;

    always_comb begin
        next_pc_o = p4;
        if (jump_i) begin
            next_pc_o = {p4[31:28], index_i, 2'b00};
        end else if (branch_i && zero_i) begin
            next_pc_o = p4 + branch_offset(imm16_i);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch FSM: PC, instruction holding register and ack timeout.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned TO_W     = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               branch_in,
    input  logic               jump_in,
    input  logic               zero_in,
    input  logic [15:0]        imm16_in,
    input  logic [25:0]        index_in,
    fetch_unit_if.master       imem,
    output logic [31:0]        instr,
    output logic               instr_valid,
    output logic [31:0]        pc,
    output logic               fetch_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        instr_count,
    output logic [31:0]        redirect_count
`endif
);

    localparam logic [TO_W-1:0] TO_MAX = '1;

    fetch_state_e    state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [31:0]     next_pc;

    next_pc_calc u_next_pc_calc (
        .pc_i      (pc_q),
        .branch_i  (branch_in),
        .jump_i    (jump_in),
        .zero_i    (zero_in),
        .imm16_i   (imm16_in),
        .index_i   (index_in),
        .next_pc_o (next_pc)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= StRst;
            pc_q     <= {RESET_PC[31:2], 2'b00};
            instr_q  <= NOP;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        to_cnt_d = to_cnt_q;
        case (state_q)
            StRst: state_d = StReq;
            StReq: begin
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    state_d = StExec;
                end else begin
                    to_cnt_d = '0;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    state_d = StExec;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (to_cnt_d == TO_MAX) begin
                        state_d = StErr;
                    end
                end
            end
            StExec: state_d = StNext;
            // Feedback registers settled at the EXEC negedge; safe to sample here.
            StNext: begin
                pc_d    = next_pc;
                state_d = StReq;
            end
            StErr:   state_d = StErr;
            default: state_d = StRst;
        endcase
    end

    assign imem.imem_req  = (state_q == StReq) || (state_q == StWait);
    assign imem.imem_addr = {pc_q[31:2], 2'b00};
    assign instr          = instr_q;
    assign instr_valid    = (state_q == StExec);
    assign pc             = pc_q;
    assign fetch_err      = (state_q == StErr);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] instr_cnt_q;
    logic [31:0] redirect_cnt_q;
    logic        redirect;

    assign redirect = jump_in || (branch_in && zero_in);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            instr_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (state_q == StExec) begin
                instr_cnt_q <= instr_cnt_q + 32'd1;
            end
            if ((state_q == StNext) && redirect) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
        end
    end

    assign instr_count    = instr_cnt_q;
    assign redirect_count = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (TO_W=3) plus a second
// instance at RESET_PC=0x3000_0000 with a same-cycle-ack memory.
module tb_fetch_unit;

    logic        CLK;
    logic        RST_N;
    logic        branch_in;
    logic        jump_in;
    logic        zero_in;
    logic [15:0] imm16_in;
    logic [25:0] index_in;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic        fetch_err;

    logic [31:0] b_instr;
    logic        b_instr_valid;
    logic [31:0] b_pc;
    logic        b_fetch_err;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] instr_count;
    logic [31:0] redirect_count;
    logic [31:0] b_instr_count;
    logic [31:0] b_redirect_count;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    fetch_unit_if imem_a ();
    fetch_unit_if imem_b ();

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .TO_W     (3)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .branch_in   (branch_in),
        .jump_in     (jump_in),
        .zero_in     (zero_in),
        .imm16_in    (imm16_in),
        .index_in    (index_in),
        .imem        (imem_a),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .fetch_err   (fetch_err)
`ifdef FETCH_PERF_CNT_EN
        ,
        .instr_count    (instr_count),
        .redirect_count (redirect_count)
`endif
    );

    fetch_unit #(
        .RESET_PC (32'h3000_0000),
        .TO_W     (8)
    ) dut_b (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .branch_in   (1'b1),
        .jump_in     (1'b1),
        .zero_in     (1'b1),
        .imm16_in    (16'h0001),
        .index_in    (26'h000_0040),
        .imem        (imem_b),
        .instr       (b_instr),
        .instr_valid (b_instr_valid),
        .pc          (b_pc),
        .fetch_err   (b_fetch_err)
`ifdef FETCH_PERF_CNT_EN
        ,
        .instr_count    (b_instr_count),
        .redirect_count (b_redirect_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory A: acks ack_delay cycles after the request first appears.
    // ack_delay=1 is a one-cycle-latency memory (ack in the first WAIT cycle).
    logic mem_ack_r = 1'b0;
    int   wait_cnt  = 0;
    int   ack_delay = 1;
    bit   ack_en    = 1'b1;
    bit   force_ack = 1'b0;

    always @(negedge CLK) begin
        if (!imem_a.imem_req) begin
            wait_cnt  = 0;
            mem_ack_r = 1'b0;
        end else begin
            mem_ack_r = ack_en && (wait_cnt == ack_delay);
            wait_cnt++;
        end
    end

    assign imem_a.imem_ack   = force_ack | mem_ack_r;
    assign imem_a.imem_rdata = mem_word(imem_a.imem_addr);
    assign imem_b.imem_ack   = imem_b.imem_req;
    assign imem_b.imem_rdata = mem_word(imem_b.imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic clear_fb();
        branch_in = 1'b0;
        jump_in   = 1'b0;
        zero_in   = 1'b0;
        imm16_in  = '0;
        index_in  = '0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_a.imem_req && n < 20) begin
            tick();
            n++;
        end
    endtask

    // Waits for the request and its EXEC cycle; caller may then set feedback.
    task automatic fetch_one(input logic [31:0] exp_addr);
        int n = 0;
        wait_req();
        check("req_addr", imem_a.imem_addr, exp_addr);
        clear_fb();
        while (!instr_valid && n < 20) begin
            tick();
            n++;
        end
        check("exec_valid", 32'(instr_valid), 32'd1);
        check("exec_instr", instr, mem_word(exp_addr));
        check("exec_pc", pc, exp_addr);
    endtask

    // Redirect flow: entry i gives the address fetched and the feedback
    // presented while it executes.
    logic [31:0] seq_addr  [10] = '{32'h00, 32'h04, 32'h10, 32'h14, 32'h10,
                                    32'h14, 32'h40, 32'h44, 32'h48, 32'h4C};
    logic [2:0]  seq_jbz   [10] = '{3'b000, 3'b011, 3'b000, 3'b011, 3'b010,
                                    3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [15:0] seq_imm   [10] = '{16'h0, 16'h0002, 16'h0, 16'hFFFE, 16'h0,
                                    16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    logic [25:0] seq_index [10] = '{26'h0, 26'h0, 26'h0, 26'h0, 26'h0,
                                    26'h10, 26'h0, 26'h0, 26'h0, 26'h0};

    initial begin : main_flow
        int last_cyc;
        RST_N = 1'b0;
        clear_fb();
        repeat (2) tick();

        check("rst_req", 32'(imem_a.imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_err", 32'(fetch_err), 32'd0);
        RST_N = 1'b1;

        // Sequential fetch, one EXEC every 4 cycles.
        last_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            fetch_one(32'(i * 4));
            if (i > 0) check("valid_period", 32'(cyc - last_cyc), 32'd4);
            last_cyc = cyc;
            tick();
            check("valid_one_cycle", 32'(instr_valid), 32'd0);
        end

        // Taken branch back, jump, then untaken branch.
        fetch_one(32'h10);
        branch_in = 1'b1; zero_in = 1'b1; imm16_in = 16'hFFFC;
        fetch_one(32'h04);
        jump_in = 1'b1; index_in = 26'h000_0004;
        fetch_one(32'h10);
        branch_in = 1'b1; zero_in = 1'b0; imm16_in = 16'hFFFC;
        fetch_one(32'h14);

        // Ack delayed 3 cycles: instr held until capture.
        ack_delay = 3;
        wait_req();
        check("delay_addr", imem_a.imem_addr, 32'h18);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("delay_hold_instr", instr, mem_word(32'h14));
            check("delay_no_valid", 32'(instr_valid), 32'd0);
        end
        tick();
        check("delay_valid", 32'(instr_valid), 32'd1);
        check("delay_instr", instr, mem_word(32'h18));

        // No ack: error after 7 WAIT cycles.
        ack_en = 1'b0;
        ack_delay = 1;
        wait_req();
        check("to_addr", imem_a.imem_addr, 32'h1C);
        repeat (7) tick();
        check("to_still_req", 32'(imem_a.imem_req), 32'd1);
        check("to_no_err_yet", 32'(fetch_err), 32'd0);
        tick();
        check("to_err", 32'(fetch_err), 32'd1);
        check("to_req_low", 32'(imem_a.imem_req), 32'd0);
        check("to_pc_frozen", pc, 32'h1C);
        force_ack = 1'b1;
        ack_en = 1'b1;
        repeat (3) tick();
        check("err_sticky", 32'(fetch_err), 32'd1);
        check("err_no_valid", 32'(instr_valid), 32'd0);
        check("err_instr", instr, mem_word(32'h18));
        force_ack = 1'b0;

        // Reset out of ERR, then async reset in the middle of a WAIT.
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        fetch_one(32'h0);
        ack_delay = 3;
        wait_req();
        check("mid_addr", imem_a.imem_addr, 32'h04);
        repeat (2) tick();
        #2 RST_N = 1'b0;
        #1;
        check("async_req", 32'(imem_a.imem_req), 32'd0);
        check("async_pc", pc, 32'h0);
        check("async_instr", instr, 32'h0);
        check("async_valid", 32'(instr_valid), 32'd0);
        check("async_err", 32'(fetch_err), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("async_icnt", instr_count, 32'd0);
        check("async_rcnt", redirect_count, 32'd0);
`endif
        force_ack = 1'b1;
        ack_delay = 1;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        tick();
        check("stray_ack_ignored", instr, 32'h0);
        check("restart_req", 32'(imem_a.imem_req), 32'd1);
        check("restart_addr", imem_a.imem_addr, 32'h0);
        force_ack = 1'b0;

        // Ten instructions with two taken branches and one jump.
        for (int i = 0; i < 10; i++) begin
            fetch_one(seq_addr[i]);
            {jump_in, branch_in, zero_in} = seq_jbz[i];
            imm16_in = seq_imm[i];
            index_in = seq_index[i];
        end
        tick();
        clear_fb();
`ifdef FETCH_PERF_CNT_EN
        check("instr_count", instr_count, 32'd10);
        check("redirect_count", redirect_count, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Second instance: same-cycle ack, jump+branch always asserted.
    initial begin : b_flow
        int n;
        @(posedge RST_N);
        n = 0;
        while (!imem_b.imem_req && n < 20) begin
            @(posedge CLK); #1; n++;
        end
        check("b_first_addr", imem_b.imem_addr, 32'h3000_0000);
        n = 0;
        while (!b_instr_valid && n < 20) begin
            @(posedge CLK); #1; n++;
        end
        check("b_exec_instr", b_instr, mem_word(32'h3000_0000));
        n = 0;
        while (!imem_b.imem_req && n < 20) begin
            @(posedge CLK); #1; n++;
        end
        check("b_jump_priority", imem_b.imem_addr, 32'h3000_0100);
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1);
    end

endmodule
